// File: rtl/dma_channel_if.sv
// DMA channel control bus: transfer window in, slot counter and pass flag out.
// The master is system control; the slave is the channel sequencer.
interface dma_channel_if #(
    parameter int CNT_W = 5
);
    logic             state;
    logic [CNT_W-1:0] count;
    logic             one;

    modport master (
        output state,
        input  count,
        input  one
    );

    modport slave (
        input  state,
        output count,
        output one
    );
endinterface

// File: rtl/dma_channel.sv
// DMA channel slot sequencer: input-phase slots, then output-phase slots.
// Optional macro DMA_CHANNEL_ONE_SHOT_EN: one pass per STATE window.
module dma_channel #(
    parameter int CNT_W = 5
) (
    input  logic         CLK,
    input  logic         CLR,
    dma_channel_if.slave bus
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             one_q;
    logic             one_d;

    // Next slot and pass-complete flag from the current window state.
    always_comb begin
        count_d = count_q;
        one_d   = one_q;
        if (!bus.state) begin
            count_d = '0;
            one_d   = 1'b0;
        end else if (one_q) begin
`ifdef DMA_CHANNEL_ONE_SHOT_EN
            // Pass done: park at slot 0 until the window closes.
            count_d = '0;
            one_d   = 1'b1;
`else
            // Flag is a one-cycle pulse; the next pass carries on.
            count_d = count_q + 1'b1;
            one_d   = 1'b0;
`endif
        end else if (count_q == '1) begin
            count_d = '0;
            one_d   = 1'b1;
        end else begin
            count_d = count_q + 1'b1;
            one_d   = 1'b0;
        end
    end

    // State registers; CLR overrides the transfer window.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            count_q <= '0;
            one_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            one_q   <= one_d;
        end
    end

    assign bus.count = count_q;
    assign bus.one   = one_q;

endmodule

// File: tb/tb_dma_channel.sv
// Directed self-checking bench for dma_channel.
// Covers reset, full passes, abort, phase split and mid-pass CLR.
module tb_dma_channel;

    localparam int CNT_W = 5;

    logic clk;
    logic clr;
    int   checks;
    int   fails;

    dma_channel_if #(.CNT_W(CNT_W)) bus ();

    dma_channel #(.CNT_W(CNT_W)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [CNT_W-1:0] exp_c;
        // STATE rising together with CLR, then CLR held 2 cycles.
        clr = 1'b1;
        bus.state = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.count !== 5'd0 || bus.one !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: count=%0d one=%b, want count=0 one=0",
                         i, bus.count, bus.one);
            end
        end
        clr = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd0) begin
            fails++;
            $display("FAIL reset_release: count=%0d, want 0", bus.count);
        end
        step();
        exp_c = 5'd1;
        checks++;
        if (bus.count !== exp_c || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_edge: count=%0d one=%b, want count=1 one=0",
                     bus.count, bus.one);
        end
        bus.state = 1'b0;
        step();
        checks++;
        if (bus.count !== 5'd0 || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: count=%0d one=%b, want 0/0", bus.count, bus.one);
        end
    endtask

    task automatic test_pass();
        int               ncyc;
        logic [CNT_W-1:0] exp_c;
        logic             exp_o;
`ifdef DMA_CHANNEL_ONE_SHOT_EN
        ncyc = 40;
`else
        ncyc = 70;
`endif
        bus.state = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            #1;
`ifdef DMA_CHANNEL_ONE_SHOT_EN
            exp_c = (c < 32) ? 5'(c) : 5'd0;
            exp_o = (c >= 32);
`else
            exp_c = 5'(c % 32);
            exp_o = (c == 32) || (c == 64);
`endif
            checks++;
            if (bus.count !== exp_c || bus.one !== exp_o) begin
                fails++;
                $display("FAIL pass_cycle[%0d]: count=%0d one=%b, want count=%0d one=%b",
                         c, bus.count, bus.one, exp_c, exp_o);
            end
            step();
        end
        bus.state = 1'b0;
        step();
        checks++;
        if (bus.count !== 5'd0 || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL pass_close: count=%0d one=%b, want 0/0", bus.count, bus.one);
        end
    endtask

    task automatic test_abort();
        bus.state = 1'b1;
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (bus.count !== 5'd9 || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL abort_mid: count=%0d one=%b, want count=9 one=0",
                     bus.count, bus.one);
        end
        bus.state = 1'b0;
        step();
        checks++;
        if (bus.count !== 5'd0 || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL abort_drop: count=%0d one=%b, want 0/0", bus.count, bus.one);
        end
        bus.state = 1'b1;
        for (int c = 0; c < 32; c++) begin
            #1;
            checks++;
            if (bus.count !== 5'(c) || bus.one !== 1'b0) begin
                fails++;
                $display("FAIL abort_restart[%0d]: count=%0d one=%b, want count=%0d one=0",
                         c, bus.count, bus.one, c);
            end
            step();
        end
        checks++;
        if (bus.count !== 5'd0 || bus.one !== 1'b1) begin
            fails++;
            $display("FAIL abort_complete: count=%0d one=%b, want count=0 one=1",
                     bus.count, bus.one);
        end
        bus.state = 1'b0;
        step();
    endtask

    task automatic test_phase_clr();
        int  n0;
        int  n1;
        int  other;
        bit  in_out;
        n0 = 0;
        n1 = 0;
        other = 0;
        in_out = 1'b0;
        bus.state = 1'b1;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (!in_out && bus.count[CNT_W-1] === 1'b0) n0++;
            else if (bus.count[CNT_W-1] === 1'b1) begin
                in_out = 1'b1;
                n1++;
            end else other++;
            step();
        end
        checks++;
        if (n0 !== 16 || n1 !== 16 || other !== 0) begin
            fails++;
            $display("FAIL phase_split: in=%0d out=%0d stray=%0d, want 16/16/0",
                     n0, n1, other);
        end
        bus.state = 1'b0;
        step();
        bus.state = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bus.count !== 5'd20) begin
            fails++;
            $display("FAIL clr_pre: count=%0d, want 20", bus.count);
        end
        clr = 1'b1;
        step();
        checks++;
        if (bus.count !== 5'd0 || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL clr_mid: count=%0d one=%b, want 0/0", bus.count, bus.one);
        end
        clr = 1'b0;
        step();
        checks++;
        if (bus.count !== 5'd1 || bus.one !== 1'b0) begin
            fails++;
            $display("FAIL clr_resume: count=%0d one=%b, want count=1 one=0",
                     bus.count, bus.one);
        end
        bus.state = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        fails = 0;
        clr = 1'b0;
        bus.state = 1'b0;
        test_reset();
        test_pass();
        test_abort();
        test_phase_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
